// File: rtl/stripe_scroll_ctrl.sv
// Frame-synchronous scroll offset / scene controller for the scrolling-stripes pattern.
// Define STRIPE_SCROLL_CTRL_AUTOSCENE_EN to enable frame counting and scene sequencing.
module stripe_scroll_ctrl #(
  parameter int FRAMES_PER_SCENE = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_speed,
  input  logic       cfg_dir,
  input  logic       cfg_pause,
  output logic [9:0] offset_x,
  output logic [9:0] offset_y,
  output logic [1:0] scene,
  output logic       frame_tick
);
  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  if (FRAMES_PER_SCENE < 1 || FRAMES_PER_SCENE > 1023) begin : g_bad_fps
    $error("FRAMES_PER_SCENE must be in 1..1023");
  end

  state_t     state_reg, state_next;
  logic       vsync_q_reg;
  logic       frame_edge, xfer, advance;
  logic [2:0] spd_reg, spd_next, pend_spd_reg, pend_spd_next;
  logic       dir_reg, dir_next, pend_dir_reg, pend_dir_next;
  logic       pause_reg, pause_next, pend_pause_reg, pend_pause_next;
  logic       pend_reg, pend_next;
  logic [9:0] offset_x_reg, offset_x_next, offset_y_reg, offset_y_next;
  logic [1:0] scene_reg;
  logic       frame_tick_reg, frame_tick_next;

  assign frame_edge = vsync & ~vsync_q_reg;
  assign xfer       = cfg_valid & ~pend_reg;

  always_comb begin
    state_next      = state_reg;
    spd_next        = spd_reg;
    dir_next        = dir_reg;
    pause_next      = pause_reg;
    pend_next       = pend_reg;
    pend_spd_next   = pend_spd_reg;
    pend_dir_next   = pend_dir_reg;
    pend_pause_next = pend_pause_reg;
    offset_x_next   = offset_x_reg;
    offset_y_next   = offset_y_reg;
    frame_tick_next = frame_edge;
    advance         = 1'b0;

    // A config waiting in the slot becomes active before this edge is evaluated.
    if (frame_edge && pend_reg) begin
      spd_next   = pend_spd_reg;
      dir_next   = pend_dir_reg;
      pause_next = pend_pause_reg;
      pend_next  = 1'b0;
    end

    if (frame_edge) begin
      state_next = pause_next ? PAUSED : RUN;
      advance    = (state_next == RUN);
    end

    if (advance) begin
      offset_x_next = dir_next ? offset_x_reg - {7'd0, spd_next}
                               : offset_x_reg + {7'd0, spd_next};
      if (scene_reg[1]) offset_y_next = offset_y_reg + 10'd1;
    end

    // The slot is only free when pend was clear, so this never collides with the apply above.
    if (xfer) begin
      pend_next       = 1'b1;
      pend_spd_next   = cfg_speed;
      pend_dir_next   = cfg_dir;
      pend_pause_next = cfg_pause;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q_reg    <= 1'b1;
      state_reg      <= RUN;
      spd_reg        <= 3'd1;
      dir_reg        <= 1'b0;
      pause_reg      <= 1'b0;
      pend_reg       <= 1'b0;
      pend_spd_reg   <= 3'd0;
      pend_dir_reg   <= 1'b0;
      pend_pause_reg <= 1'b0;
      offset_x_reg   <= 10'd0;
      offset_y_reg   <= 10'd0;
      frame_tick_reg <= 1'b0;
    end else begin
      vsync_q_reg    <= vsync;
      state_reg      <= state_next;
      spd_reg        <= spd_next;
      dir_reg        <= dir_next;
      pause_reg      <= pause_next;
      pend_reg       <= pend_next;
      pend_spd_reg   <= pend_spd_next;
      pend_dir_reg   <= pend_dir_next;
      pend_pause_reg <= pend_pause_next;
      offset_x_reg   <= offset_x_next;
      offset_y_reg   <= offset_y_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

`ifdef STRIPE_SCROLL_CTRL_AUTOSCENE_EN
  localparam logic [9:0] FCNT_LAST = 10'(FRAMES_PER_SCENE - 1);

  logic [9:0] fcnt_reg, fcnt_next;
  logic [1:0] scene_next;

  always_comb begin
    fcnt_next  = fcnt_reg;
    scene_next = scene_reg;
    if (advance) begin
      if (fcnt_reg == FCNT_LAST) begin
        fcnt_next  = 10'd0;
        scene_next = scene_reg + 2'd1;
      end else begin
        fcnt_next = fcnt_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_reg  <= 10'd0;
      scene_reg <= 2'd0;
    end else begin
      fcnt_reg  <= fcnt_next;
      scene_reg <= scene_next;
    end
  end
`else
  assign scene_reg = 2'd0;
`endif

  assign cfg_ready  = ~pend_reg;
  assign offset_x   = offset_x_reg;
  assign offset_y   = offset_y_reg;
  assign scene      = scene_reg;
  assign frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_stripe_scroll_ctrl.sv
// Testbench for stripe_scroll_ctrl: directed vector table, corner sequences and a
// randomized run compared cycle by cycle against a frame-count based reference model.
module tb_stripe_scroll_ctrl;
  localparam int FPS = 4;
`ifdef STRIPE_SCROLL_CTRL_AUTOSCENE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk, reset, vsync, cfg_valid, cfg_ready, cfg_dir, cfg_pause, frame_tick;
  logic [2:0] cfg_speed;
  logic [9:0] offset_x, offset_y;
  logic [1:0] scene;

  stripe_scroll_ctrl #(.FRAMES_PER_SCENE(FPS)) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_speed(cfg_speed), .cfg_dir(cfg_dir), .cfg_pause(cfg_pause),
    .offset_x(offset_x), .offset_y(offset_y), .scene(scene), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the number of advanced frames; scene derives from that count.
  bit m_prev_v, m_pend, m_dir, m_pause, p_dir, p_pause, m_tick;
  int m_spd, p_spd, m_ox, m_oy, m_frames;

  function automatic int exp_scene();
    return AUTO ? (m_frames / FPS) % 4 : 0;
  endfunction

  task automatic model_step();
    bit e, take;
    if (reset) begin
      m_prev_v = 1'b1; m_pend = 1'b0; m_spd = 1; m_dir = 1'b0; m_pause = 1'b0;
      m_ox = 0; m_oy = 0; m_frames = 0; m_tick = 1'b0;
    end else begin
      e = vsync && !m_prev_v;
      m_prev_v = vsync;
      take = cfg_valid && !m_pend;
      m_tick = e;
      if (e) begin
        if (m_pend) begin
          m_spd = p_spd; m_dir = p_dir; m_pause = p_pause; m_pend = 1'b0;
        end
        if (!m_pause) begin
          if (exp_scene() >= 2) m_oy = (m_oy + 1) % 1024;
          m_ox = m_dir ? (m_ox - m_spd + 1024) % 1024 : (m_ox + m_spd) % 1024;
          m_frames++;
        end
      end
      if (take) begin
        m_pend = 1'b1; p_spd = int'(cfg_speed); p_dir = cfg_dir; p_pause = cfg_pause;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_cnt++;
    if (chk_on) begin
      chk("cyc_offset_x", 32'(offset_x), 32'(m_ox));
      chk("cyc_offset_y", 32'(offset_y), 32'(m_oy));
      chk("cyc_scene", 32'(scene), 32'(exp_scene()));
      chk("cyc_frame_tick", 32'(frame_tick), 32'(m_tick));
      chk("cyc_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic vs_edge();
    vsync = 1'b0; tick(3);
    vsync = 1'b1; tick(3);
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_valid = 1'b0; tick(2);
    reset = 1'b0;
  endtask

  task automatic send_cfg(input logic [2:0] s, input logic d, input logic p);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin tick(1); n++; end
    if (n == 50) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    cfg_speed = s; cfg_dir = d; cfg_pause = p; cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    bit         send;
    logic [2:0] spd;
    bit         dir;
    bit         pause;
    int         edges;
    logic [9:0] exp_ox;
    bit         exp_ready;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int tc;
    tbl[0] = '{1'b0, 3'd0, 1'b0, 1'b0, 2, 10'd2,    1'b1};
    tbl[1] = '{1'b1, 3'd7, 1'b1, 1'b0, 0, 10'd2,    1'b0};
    tbl[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 1, 10'd1019, 1'b1};
    tbl[3] = '{1'b1, 3'd7, 1'b1, 1'b1, 5, 10'd1019, 1'b1};
    tbl[4] = '{1'b1, 3'd3, 1'b0, 1'b0, 1, 10'd1022, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1, 10'd1,    1'b1};
    tbl[6] = '{1'b1, 3'd0, 1'b0, 1'b0, 2, 10'd1,    1'b1};
    tbl[7] = '{1'b1, 3'd2, 1'b1, 1'b0, 1, 10'd1023, 1'b1};

    reset = 1'b1; vsync = 1'b0; cfg_valid = 1'b0;
    cfg_speed = 3'd0; cfg_dir = 1'b0; cfg_pause = 1'b0;
    tick(2);
    chk_on = 1'b1;
    chk("rst_offset_x", 32'(offset_x), 32'd0);
    chk("rst_offset_y", 32'(offset_y), 32'd0);
    chk("rst_scene", 32'(scene), 32'd0);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    // Three frames with default config.
    tc = tick_cnt;
    repeat (3) vs_edge();
    chk("three_frames_ox", 32'(offset_x), 32'd3);
    chk("three_frames_oy", 32'(offset_y), 32'd0);
    chk("three_frames_scene", 32'(scene), 32'd0);
    chk("three_frames_ticks", 32'(tick_cnt - tc), 32'd3);

    // Vector table, starting from a fresh reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tc = tick_cnt;
      if (tbl[i].send) begin
        send_cfg(tbl[i].spd, tbl[i].dir, tbl[i].pause);
        chk($sformatf("vec%0d_ready_low", i), 32'(cfg_ready), 32'd0);
      end
      for (int k = 0; k < tbl[i].edges; k++) vs_edge();
      chk($sformatf("vec%0d_ox", i), 32'(offset_x), 32'(tbl[i].exp_ox));
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_ticks", i), 32'(tick_cnt - tc), 32'(tbl[i].edges));
    end

    // Eight frames advanced so far: scene boundary checks.
    chk("scene_after8", 32'(scene), AUTO ? 32'd2 : 32'd0);
    chk("oy_after8", 32'(offset_y), 32'd0);
    repeat (4) vs_edge();
    chk("scene_after12", 32'(scene), AUTO ? 32'd3 : 32'd0);
    chk("oy_after12", 32'(offset_y), AUTO ? 32'd4 : 32'd0);
    chk("ox_after12", 32'(offset_x), 32'd1015);

    // Config transfer coincident with an edge lands at the following edge.
    vsync = 1'b0; tick(3);
    vsync = 1'b1; cfg_valid = 1'b1; cfg_speed = 3'd5; cfg_dir = 1'b0; cfg_pause = 1'b0;
    tick(1);
    cfg_valid = 1'b0;
    chk("coinc_ox", 32'(offset_x), 32'd1013);
    chk("coinc_tick", 32'(frame_tick), 32'd1);
    chk("coinc_ready", 32'(cfg_ready), 32'd0);
    tick(2);
    vs_edge();
    chk("coinc_next_ox", 32'(offset_x), 32'd1018);
    chk("coinc_next_ready", 32'(cfg_ready), 32'd1);

    // Reset while a config is pending, with vsync rising in the reset cycle and held high.
    send_cfg(3'd4, 1'b1, 1'b0);
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    vsync = 1'b0; tick(2);
    reset = 1'b1; vsync = 1'b1; tick(1);
    reset = 1'b0;
    chk("mid_rst_ox", 32'(offset_x), 32'd0);
    chk("mid_rst_oy", 32'(offset_y), 32'd0);
    chk("mid_rst_scene", 32'(scene), 32'd0);
    chk("mid_rst_tick", 32'(frame_tick), 32'd0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
    tc = tick_cnt;
    tick(20);
    chk("held_high_no_edge", 32'(tick_cnt - tc), 32'd0);
    vs_edge();
    chk("discarded_cfg_ox", 32'(offset_x), 32'd1);

    // Long vsync high yields one edge.
    tc = tick_cnt;
    vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(60);
    chk("long_high_ticks", 32'(tick_cnt - tc), 32'd1);
    chk("long_high_ox", 32'(offset_x), 32'd2);

    // Randomized run; the per-cycle model comparison does the checking.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_speed = 3'($urandom_range(0, 7));
      cfg_dir   = 1'($urandom_range(0, 1));
      cfg_pause = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    reset = 1'b0; cfg_valid = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stripe_scroll_ctrl.md
# stripe_scroll_ctrl

Frame-synchronous animation controller for the scrolling-stripes VGA pattern. It detects frame boundaries from the `vsync` output of `hvsync_generator` in the pixel clock domain, so the pattern logic no longer needs a separate vsync-clocked register. It produces per-frame scroll offsets and a scene index, which the pattern datapath adds to `hpos`/`vpos`. Runtime speed, direction and pause settings arrive over a valid/ready handshake and take effect only on a frame boundary, so a frame is never torn mid-scan.

## Interface
Parameters:
- `FRAMES_PER_SCENE`, default 240: frames per scene before the scene index advances; legal range 1..1023.

Ports:
- `clk`  in  1  pixel clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  vsync from `hvsync_generator`, synchronous to `clk`. A frame boundary is a sampled 0→1 transition.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  block can accept a config.
- `cfg_speed`  in  3  pixels per frame added to or subtracted from `offset_x`.
- `cfg_dir`  in  1  0 = `offset_x` increases, 1 = `offset_x` decreases.
- `cfg_pause`  in  1  1 = freeze the animation.
- `offset_x`  out  10  horizontal scroll offset.
- `offset_y`  out  10  vertical scroll offset.
- `scene`  out  2  current scene index.
- `frame_tick`  out  1  one-cycle pulse per detected frame boundary.

## Operation
- Edge detect: `vsync_q <= vsync`; `edge = vsync & ~vsync_q`.
  - Reset loads `vsync_q = 1`, so no edge is seen until `vsync` has been observed low and then high.
- Active config registers (`spd`, `dir`, `pause`) reset to spd=1, dir=0, pause=0.
- Pending config slot: a single entry with flag `pend`, reset 0. `cfg_ready = ~pend`.
  - A transfer occurs when `cfg_valid & cfg_ready`. The fields are captured and `pend` is set.
- On an `edge` cycle, in this order:
  - If `pend` was set before this cycle, copy the pending fields to active and clear `pend`.
  - A transfer in the same cycle as an edge goes to pending and is applied at the next edge, not this one.
  - Then evaluate the FSM using the new active values.
- FSM states are RUN and PAUSED; reset enters RUN. The state is re-evaluated only on an edge.
  - State becomes PAUSED if active pause=1, else RUN.
  - A frame advances only if the post-apply state is RUN.
  - A pause edge does not advance. An unpause edge does advance.
- Frame advance:
  - `offset_x` ← `offset_x ± spd`, modulo 1024. Wraps 1023+1→0 and 0−1→1023.
  - spd=0 means no motion, but the frame still counts.
  - `offset_y` ← `offset_y + 1` (mod 1024) when `scene[1]=1` (value before this edge), else hold.
  - Frame counter `fcnt` (10 bits): if `fcnt == FRAMES_PER_SCENE-1`, set `fcnt` to 0 and `scene` to `scene+1` (mod 4). Otherwise `fcnt+1`.
- PAUSED: offsets, `fcnt` and `scene` hold. `frame_tick` still pulses, and config is still applied.

## Timing
- Reset values: `offset_x`=0, `offset_y`=0, `scene`=0, `fcnt`=0, `frame_tick`=0, `cfg_ready`=1.
- `reset` overrides all activity in the same cycle, including a coincident edge or cfg transfer.
- Asserting reset mid-frame discards the pending config.
- All outputs are registered. The edge is detected at clock edge N, where `vsync` is sampled 1 and `vsync_q` is 0.
  - New `offset_x`/`offset_y`/`scene` and `frame_tick`=1 are visible in cycle N+1.
  - `frame_tick` is high exactly one cycle.
- `cfg_ready` falls the cycle after a transfer. It rises the cycle after the applying edge.
  - Minimum spacing between accepted configs is one frame.
- `cfg_*` are ignored while `cfg_ready`=0. Holding `cfg_valid` high retries until accepted.
- `vsync` held high for many cycles produces exactly one edge.

## Configuration
- `STRIPE_SCROLL_CTRL_AUTOSCENE_EN` defined: the `fcnt`/`scene` sequencing above is present.
- Not defined:
  - `fcnt` logic is omitted and `scene` is constant 0.
  - Consequently `offset_y` stays 0.
  - `offset_x`, the config handshake and the FSM are unchanged.

## Test plan
- Reset, then 3 vsync pulses with no config → `offset_x`=3, `offset_y`=0, `scene`=0, three single-cycle `frame_tick` pulses.
- Config spd=7, dir=1 accepted mid-frame → `cfg_ready`=0 until the next edge. That edge gives `offset_x` = previous−7 mod 1024; starting from 2, it reads 1019.
- Config pause=1, then 5 edges → offsets frozen and 5 `frame_tick` pulses. Config pause=0, then 1 edge → `offset_x` advances once.
- `FRAMES_PER_SCENE`=4 with macro defined, 8 edges → `scene`=2 after edge 8 and `offset_y`=0 at that point. Edges 9..12 → `offset_y`=4. Without the macro → `scene`=0 throughout.
- `cfg_valid` in the same cycle as an edge → not applied at that edge, applied at the following edge.
- `vsync`=1 held through the reset release → no edge until `vsync` goes 0 then 1. Assert reset during `cfg_ready`=0 → `cfg_ready`=1 and all outputs at reset values next cycle.
